alu_share_arbiter: RTL and testbench

Shares the single combinational ALU between NUM_REQ requesters, e.g. the execute stage and a PC/address-calc unit.
- Round-robin arbitration over valid/ready requests.
- Registers the winner's operands and ALU_OP onto the ALU inputs.
- Captures o_data and B_PCSrc into a response register and returns them to the granted requester under valid/ready.
- Sits between the control/datapath and the ALU instance in the 8-bit CPU.

---
 rtl/alu_arb_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/alu_share_arbiter.sv | 101 ++++++++++
 tb/tb_alu_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared ALU_OP encoding, widths and FSM state for the ALU share arbiter.
// ALU_OP layout: {FUN[6:4], OP[3:2] class, OP[1:0] sub-code}.
package alu_arb_pkg;

  localparam int OP_W   = 7;
  localparam int DATA_W = 8;

  // OP[3:2] instruction class
  localparam logic [1:0] ALU_CAL     = 2'b00;
  localparam logic [1:0] ALU_IMM     = 2'b01;
  localparam logic [1:0] BRANCH      = 2'b10;
  localparam logic [1:0] BRANCH_JUMP = 2'b11;

  // OP[1:0] sub-code for ALU_CAL / ALU_IMM
  localparam logic [1:0] NUM_CAL = 2'b00;
  localparam logic [1:0] BIN_CAL = 2'b01;

  // FUN codes; NUM_CAL code 3 is left undefined in the ALU
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] MUL = 3'd2;
  localparam logic [2:0] AND = 3'd0;
  localparam logic [2:0] OR  = 3'd1;
  localparam logic [2:0] XOR = 3'd2;
  localparam logic [2:0] BEQ = 3'd0;
  localparam logic [2:0] BNE = 3'd1;
  localparam logic [2:0] JAL = 3'd0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

  function automatic logic [OP_W-1:0] mk_op(input logic [2:0] fun, input logic [1:0] cls,
                                            input logic [1:0] sub);
    return {fun, cls, sub};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant over a request vector, searching from ptr+1 round-robin.
// With ALU_ARB_FIXED_PRIO_EN defined: lowest index wins and there is no ptr port.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IDX_W'(k);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    // first candidate is the one after the last winner
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: IDLE grant -> EXEC -> RESP.
// Build option ALU_ARB_FIXED_PRIO_EN swaps round-robin for fixed lowest-index priority.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_branch,
  output logic                      busy,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_r0,
  output logic [DATA_W-1:0]         alu_r1,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_branch
);
  import alu_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e                        state;
  logic [IDX_W-1:0]                  owner;
  logic [NUM_REQ-1:0]                gnt;
  logic [IDX_W-1:0]                  gnt_idx;
  logic [NUM_REQ-1:0][OP_W-1:0]      op_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]    a_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]    b_v;

  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
`else
  logic [IDX_W-1:0] ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                      ptr <= IDX_W'(NUM_REQ - 1);
    else if (state == IDLE && |gnt)  ptr <= gnt_idx;
`endif

  // rst_n gate keeps req_ready low while reset is held even though state already reads IDLE
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      alu_op     <= '0;
      alu_r0     <= '0;
      alu_r1     <= '0;
      rsp_data   <= '0;
      rsp_branch <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          alu_op <= op_v[gnt_idx];
          alu_r0 <= a_v[gnt_idx];
          alu_r1 <= b_v[gnt_idx];
          owner  <= gnt_idx;
          state  <= EXEC;
        end
        EXEC: begin
          rsp_data   <= alu_result;
          rsp_branch <= alu_branch;
          state      <= RESP;
        end
        RESP: if (rsp_ready[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU stub and a response scoreboard.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int NR = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NR-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*OP_W-1:0]   req_op;
  logic [NR*DATA_W-1:0] req_a, req_b;
  logic [DATA_W-1:0]    rsp_data, alu_r0, alu_r1, alu_result;
  logic [OP_W-1:0]      alu_op;
  logic                 rsp_branch, busy, alu_branch;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_branch(rsp_branch), .busy(busy),
    .alu_op(alu_op), .alu_r0(alu_r0), .alu_r1(alu_r1),
    .alu_result(alu_result), .alu_branch(alu_branch)
  );

  // ALU stub standing in for the CPU's combinational ALU
  always_comb begin
    alu_result = '0;
    alu_branch = 1'b0;
    case (alu_op[3:2])
      ALU_CAL, ALU_IMM:
        if (alu_op[1:0] == NUM_CAL)
          case (alu_op[6:4])
            ADD:     alu_result = alu_r0 + alu_r1;
            SUB:     alu_result = alu_r0 - alu_r1;
            MUL:     alu_result = alu_r0 * alu_r1;
            default: alu_result = '0;
          endcase
        else if (alu_op[1:0] == BIN_CAL)
          case (alu_op[6:4])
            AND:     alu_result = alu_r0 & alu_r1;
            OR:      alu_result = alu_r0 | alu_r1;
            XOR:     alu_result = alu_r0 ^ alu_r1;
            default: alu_result = '0;
          endcase
      BRANCH:
        case (alu_op[6:4])
          BEQ:     alu_branch = (alu_r0 == alu_r1);
          BNE:     alu_branch = (alu_r0 != alu_r1);
          default: alu_branch = 1'b0;
        endcase
      BRANCH_JUMP: alu_branch = 1'b1;
      default: ;
    endcase
  end

  typedef struct {int idx; logic [7:0] data; logic br;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic b);
    sb.push_back('{i, d, b});
  endtask

  // responses are checked on the cycle their handshake completes
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("rsp_owner",  32'(rsp_valid),  32'(1 << mon_e.idx));
          chk("rsp_data",   32'(rsp_data),   32'(mon_e.data));
          chk("rsp_branch", 32'(rsp_branch), 32'(mon_e.br));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[i*OP_W +: OP_W]     = op;
    req_a[i*DATA_W +: DATA_W]  = a;
    req_b[i*DATA_W +: DATA_W]  = b;
    req_valid[i]               = 1'b1;
  endtask

  task automatic wait_grant(input int i, input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 30) begin @(negedge clk); n++; end
    chk(tag, 32'(req_ready[i]), 32'd1);
    @(posedge clk); #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input string tag);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid[i] && n < 30) begin @(negedge clk); n++; end
    chk(tag, 32'(rsp_valid[i]), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic one_op(input int i, input logic [6:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input string tag);
    push(i, ed, eb);
    set_req(i, op, a, b);
    wait_grant(i, tag);
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4];
    int n, cyc;
    req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;

    // reset state, with requests present
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_rsp_data",   32'(rsp_data),   32'd0);
    chk("rst_rsp_branch", 32'(rsp_branch), 32'd0);
    chk("rst_alu_op",     32'(alu_op),     32'd0);
    chk("rst_alu_r0",     32'(alu_r0),     32'd0);
    chk("rst_alu_r1",     32'(alu_r1),     32'd0);
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD with cycle-exact latency
    rsp_ready = 2'b11;
    push(0, 8'h08, 1'b0);
    set_req(0, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h05, 8'h03);
    @(negedge clk);
    chk("add_ready_T", 32'(req_ready), 32'd1);
    chk("add_busy_T",  32'(busy),      32'd0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("add_rsp_valid_T1", 32'(rsp_valid), 32'd0);
    chk("add_busy_T1",      32'(busy),      32'd1);
    chk("add_alu_op",       32'(alu_op),    32'(mk_op(ADD, ALU_CAL, NUM_CAL)));
    chk("add_alu_r0",       32'(alu_r0),    32'h05);
    chk("add_alu_r1",       32'(alu_r1),    32'h03);
    @(negedge clk);
    chk("add_rsp_valid_T2", 32'(rsp_valid), 32'd1);
    drain("add_drain");

    // both requesters continuously valid, from fresh reset
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1};
`endif
    for (int j = 0; j < 4; j++) push(order[j], (order[j] == 0) ? 8'h0F : 8'hFF, 1'b0);
    set_req(0, mk_op(SUB, ALU_CAL, NUM_CAL), 8'h10, 8'h01);
    set_req(1, mk_op(XOR, ALU_CAL, BIN_CAL), 8'hF0, 8'h0F);
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (|req_ready) begin
        chk($sformatf("rr_grant%0d", n), 32'(req_ready), 32'(1 << order[n]));
        n++;
      end
    end
    chk("rr_grants_seen", 32'(n), 32'd4);
    @(posedge clk); #1 req_valid = '0;
    drain("rr_drain");

    // branch outcomes and arithmetic edge cases
    one_op(1, mk_op(BEQ, BRANCH, 2'b00),      8'h2A, 8'h2A, 8'h00, 1'b1, "beq");
    one_op(1, mk_op(BNE, BRANCH, 2'b00),      8'h2A, 8'h2A, 8'h00, 1'b0, "bne");
    one_op(1, mk_op(JAL, BRANCH_JUMP, 2'b00), 8'h00, 8'h00, 8'h00, 1'b1, "jal");
    one_op(0, mk_op(MUL, ALU_CAL, NUM_CAL),   8'h10, 8'h10, 8'h00, 1'b0, "mul_trunc");
    one_op(0, mk_op(3'd3, ALU_CAL, NUM_CAL),  8'h12, 8'h34, 8'h00, 1'b0, "undef_op");

    // response backpressure with a competing requester
    rsp_ready = 2'b00;
    push(0, 8'h33, 1'b0);
    set_req(0, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h11, 8'h22);
    wait_grant(0, "bp_grant0");
    push(1, 8'hFF, 1'b0);
    set_req(1, mk_op(XOR, ALU_CAL, BIN_CAL), 8'hAA, 8'h55);
    rsp_ready = 2'b10;
    wait_rsp(0, "bp_rsp0");
    for (int j = 0; j < 5; j++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data",  32'(rsp_data),  32'h33);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy",      32'(busy),      32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_no_grant_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_grant1_next", 32'(req_ready), 32'd2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    drain("bp_drain");

    // reset during EXEC: op discarded, pointer back to NUM_REQ-1
    set_req(0, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h01, 8'h01);
    wait_grant(0, "rx_grant");
    chk("rx_in_exec", 32'(busy), 32'd1);
    set_req(0, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h02, 8'h02);
    set_req(1, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h03, 8'h03);
    rst_n = 1'b0;
    #1;
    chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rx_req_ready", 32'(req_ready), 32'd0);
    chk("rx_busy",      32'(busy),      32'd0);
    chk("rx_alu_op",    32'(alu_op),    32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    push(0, 8'h04, 1'b0);
    @(negedge clk);
    chk("rx_first_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    drain("rx_drain");

    // reset during RESP
    rsp_ready = 2'b00;
    set_req(0, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h05, 8'h05);
    wait_grant(0, "rr2_grant");
    wait_rsp(0, "rr2_in_resp");
    set_req(0, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h06, 8'h06);
    set_req(1, mk_op(ADD, ALU_CAL, NUM_CAL), 8'h07, 8'h07);
    rst_n = 1'b0;
    #1;
    chk("rr2_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rr2_req_ready", 32'(req_ready), 32'd0);
    chk("rr2_busy",      32'(busy),      32'd0);
    chk("rr2_alu_op",    32'(alu_op),    32'd0);
    @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 2'b11;
    push(0, 8'h0C, 1'b0);
    @(negedge clk);
    chk("rr2_first_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    drain("rr2_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
